// File: rtl/approx_prod_accum.sv
// Saturating burst accumulator for the approximate multiplier's product stream.
// Sums up to MAX_LEN products per burst and presents one held result per burst.
module approx_prod_accum #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sat;

  logic               accept;
  logic [ACC_W-1:0]   acc_base;
  logic [CNT_W-1:0]   cnt_base;
  logic               sat_base;
  logic [ACC_W:0]     sum_wide;
  logic               ovf;
  logic [ACC_W-1:0]   acc_upd;
  logic [CNT_W-1:0]   cnt_upd;
  logic               sat_upd;
  logic               burst_end;

  assign in_ready = (state != HOLD) && !flush;
  assign accept   = in_valid && in_ready;

  // IDLE starts a fresh burst, so stale accumulator contents never leak in
  always_comb begin
    acc_base  = (state == IDLE) ? '0 : acc;
    cnt_base  = (state == IDLE) ? '0 : cnt;
    sat_base  = (state == IDLE) ? 1'b0 : sat;
    sum_wide  = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, in_prod};
    ovf       = sum_wide[ACC_W];
    acc_upd   = ovf ? '1 : sum_wide[ACC_W-1:0];
    sat_upd   = sat_base || ovf;
    cnt_upd   = cnt_base + CNT_W'(1);
    burst_end = in_last || (cnt_upd == CNT_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          // flush is deliberately ignored here so a finished result is never lost
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
          end
        end
        default: begin
          if (flush) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
          end else if (accept) begin
            acc <= acc_upd;
            cnt <= cnt_upd;
            sat <= sat_upd;
            if (burst_end) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_upd;
              out_count <= cnt_upd;
              out_sat   <= sat_upd;
            end else begin
              state <= ACCUM;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed bench for approx_prod_accum using a narrow accumulator and short bursts
// so saturation and the forced burst end are reachable with a handful of vectors.
module tb_approx_prod_accum;

  localparam int ACC_W   = 17;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  int errors = 0;
  int checks = 0;

  approx_prod_accum #(
    .ACC_W  (ACC_W),
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] prod;
    logic        last;
    logic        fl;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ovalid;
    logic [31:0] exp_sum;
    logic [31:0] exp_cnt;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [15:0] p, logic l, logic f, logic r,
                              logic erdy, logic eov, logic [31:0] es,
                              logic [31:0] ec, logic esat);
    vec_t t;
    t.valid = v; t.prod = p; t.last = l; t.fl = f; t.ordy = r;
    t.exp_rdy = erdy; t.exp_ovalid = eov; t.exp_sum = es;
    t.exp_cnt = ec; t.exp_sat = esat;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string tag, input logic eov, input logic [31:0] es,
                           input logic [31:0] ec, input logic esat);
    checkOutput({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, eov});
    checkOutput({tag, " out_sum"}, {15'b0, out_sum}, es);
    checkOutput({tag, " out_count"}, {29'b0, out_count}, ec);
    checkOutput({tag, " out_sat"}, {31'b0, out_sat}, {31'b0, esat});
  endtask

  // drive one cycle: in_ready is checked before the edge, registered outputs after it
  task automatic applyStimulus(input string tag, input vec_t t);
    in_valid  = t.valid;
    in_prod   = t.prod;
    in_last   = t.last;
    flush     = t.fl;
    out_ready = t.ordy;
    #1;
    checkOutput({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, t.exp_rdy});
    @(posedge clk);
    #1;
    checkRegs(tag, t.exp_ovalid, t.exp_sum, t.exp_cnt, t.exp_sat);
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkRegs("reset", 1'b0, 0, 0, 1'b0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);

    // three-product burst
    vecs.push_back(mk(1, 100, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 200, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 300, 1, 0, 1, 1, 1, 600, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 600, 3, 0));
    // backpressure on a single 0xFFFF product
    vecs.push_back(mk(1, 16'hFFFF, 1, 0, 0, 1, 1, 65535, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 16'h1234, 0, 0, 0, 0, 1, 65535, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 65535, 1, 0));
    // forced end at MAX_LEN, fifth product opens a new single-product burst
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 65535, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 4, 4, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 4, 4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    // saturation at 2^17-1
    vecs.push_back(mk(1, 16'hFFFF, 0, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'hFFFF, 0, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0002, 1, 0, 1, 1, 1, 32'h1FFFF, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h1FFFF, 3, 1));
    // flush mid-burst drops 50+60 and refuses the 70
    vecs.push_back(mk(1, 50, 0, 0, 1, 1, 0, 32'h1FFFF, 3, 1));
    vecs.push_back(mk(1, 60, 0, 0, 1, 1, 0, 32'h1FFFF, 3, 1));
    vecs.push_back(mk(1, 70, 0, 1, 1, 0, 0, 32'h1FFFF, 3, 1));
    vecs.push_back(mk(1, 5, 1, 0, 1, 1, 1, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 5, 1, 0));
    // flush while a result is held has no effect
    vecs.push_back(mk(1, 7, 1, 0, 0, 1, 1, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 7, 1, 0));

    foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // reset while a result is held
    applyStimulus("r6a", mk(1, 100, 0, 0, 0, 1, 0, 7, 1, 0));
    applyStimulus("r6b", mk(1, 200, 0, 0, 0, 1, 0, 7, 1, 0));
    applyStimulus("r6c", mk(1, 300, 1, 0, 0, 1, 1, 600, 3, 0));
    idleInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkRegs("hold_rst", 1'b0, 0, 0, 1'b0);
    #1;
    checkOutput("hold_rst in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus("post_rst", mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    // reset mid-burst discards the partial sum
    applyStimulus("mid_a", mk(1, 10, 0, 0, 1, 1, 0, 0, 0, 0));
    applyStimulus("mid_b", mk(1, 20, 0, 0, 1, 1, 0, 0, 0, 0));
    idleInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("mid_c", mk(1, 3, 1, 0, 0, 1, 1, 3, 1, 0));
    applyStimulus("mid_d", mk(0, 0, 0, 0, 1, 0, 0, 3, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_prod_accum.md
Name: approx_prod_accum

Overview:
- Downstream consumer of the 8x8 approximate multiplier's 16-bit product stream.
- Accumulates a burst of products into a saturating sum and emits one result per burst.
- A burst ends on in_last or when MAX_LEN products have been taken.
- Sits between the multiplier array and the dot-product / error-evaluation logic.
- Valid/ready handshake on both sides.

Parameters:
- ACC_W, 24, accumulator and output sum width in bits; must be ≥ 16.
- MAX_LEN, 256, maximum number of products per burst; forced end of burst when reached.
- CNT_W, 9, width of the product counter; must hold the value MAX_LEN.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product on in_prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  16  unsigned product from the multiplier.
- in_last  input  1  qualifies in_prod as the final product of the burst.
- flush  input  1  synchronous discard of the partial burst.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream takes the result.
- out_sum  output  ACC_W  saturated sum of the burst.
- out_count  output  CNT_W  number of products in the burst (1..MAX_LEN).
- out_sat  output  1  saturation occurred at least once in the burst.

Behaviour:
- Clock and reset: one clock domain. rst is sampled only on the clk rising edge and has priority over everything.
- Reset values:
  - state = IDLE; accumulator = 0; counter = 0; sticky saturation flag = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_sat = 0.
  - in_ready = 1 in the cycle after reset releases, unless flush is high.
  - Reset asserted mid-burst or while a result is pending discards everything; no result is emitted.
- States:
  - IDLE: no products accepted yet.
  - ACCUM: at least one product taken.
  - HOLD: result presented.
- in_ready:
  - in_ready = (state != HOLD) && !flush.
  - This is a combinational function of state and flush only; it never depends on in_valid.
- Accept:
  - Accept = in_valid && in_ready.
  - Accumulator update: acc_next = min(acc + zero-extended in_prod, 2^ACC_W − 1).
  - Sticky saturation flag sets if the unclamped sum exceeds 2^ACC_W − 1.
  - Counter increments by 1.
  - In IDLE, the accumulator, counter and saturation flag are treated as 0; the first product starts a fresh burst.
- End of burst:
  - The burst ends on an accept with in_last = 1, or an accept where counter + 1 == MAX_LEN.
  - Next cycle: out_sum, out_count and out_sat are registered from the updated values, out_valid = 1, state = HOLD.
  - Latency: one cycle from the final accept to out_valid.
- Non-final accept: state goes to ACCUM.
- HOLD:
  - out_valid stays high; out_sum, out_count and out_sat stay stable until out_ready = 1.
  - On the cycle out_valid && out_ready: state goes to IDLE, and the accumulator, counter and flag clear.
  - out_valid = 0 the following cycle.
  - No back-to-back overlap: new products are accepted from the cycle after the handshake.
- flush:
  - In IDLE or ACCUM: clears the accumulator, counter and flag, state goes to IDLE, and any product presented that cycle is not accepted (in_ready = 0).
  - In HOLD: flush is ignored; the pending result is still delivered.
- in_last in IDLE: a single-product burst, giving out_count = 1.
- Counter: never wraps; it is capped by the forced end at MAX_LEN.
- Outputs are registered; no combinational path from in_* to out_*.
- out_sum is not updated outside the HOLD load.

Test Plan:
1. Three-product burst:
   - Stimulus: rst for 2 cycles, then in_prod = 100, 200, 300 on consecutive cycles, in_last on the third, out_ready = 1.
   - Required: out_valid one cycle after the third accept; out_sum = 600, out_count = 3, out_sat = 0; in_ready = 0 during HOLD.
2. Backpressure:
   - Stimulus: burst of one product 0xFFFF with in_last, out_ready held low for 5 cycles.
   - Required: out_valid stays high with out_sum = 65535 and out_count = 1 stable for all 5 cycles; in_valid attempts are not accepted; the result clears one cycle after out_ready = 1.
3. Forced end of burst:
   - Stimulus: MAX_LEN = 4, in_prod = 1 every cycle, in_last never asserted.
   - Required: a result after the 4th accept with out_sum = 4, out_count = 4; the 5th product starts a new burst.
4. Saturation:
   - Stimulus: ACC_W = 17, products 0xFFFF, 0xFFFF, 0x0002, in_last on the third.
   - Required: out_sum = 0x1FFFF, out_sat = 1, out_count = 3.
5. Flush mid-burst:
   - Stimulus: accept 50, 60; assert flush with in_valid = 1 and in_prod = 70; then send 5 with in_last.
   - Required: in_ready = 0 during flush; the result is out_sum = 5, out_count = 1.
6. Reset in HOLD:
   - Stimulus: out_valid high with out_sum = 600; assert rst for 1 cycle.
   - Required: out_valid = 0 and out_sum = 0 the next cycle; in_ready = 1 afterwards; no stale result reappears.
